// File: rtl/crc8_serial_unit.sv
// crc8_serial_unit: bit-serial MSB-first CRC-8 engine with valid/ready byte input and per-frame CRC strobe
module crc8_serial_unit #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] IN_DATA,
  input  logic       IN_LAST,
  output logic [7:0] CRC_OUT,
  output logic       CRC_VALID,
  output logic       BUSY
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] crc_q, crc_d, sh_q, sh_d, crc_out_q, crc_out_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q, last_d, crc_valid_q, crc_valid_d, fb;
  assign fb        = crc_q[7] ^ sh_q[7];
  assign IN_READY  = state_q == IDLE;
  assign BUSY      = state_q != IDLE;
  assign CRC_OUT   = crc_out_q;
  assign CRC_VALID = crc_valid_q;
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    crc_out_d   = crc_out_q;
    crc_valid_d = 1'b0;
    if (CLR) begin
      state_d = IDLE;
      crc_d   = INIT;
    end else begin
      case (state_q)
        IDLE: if (IN_VALID) begin
          state_d = SHIFT;
          sh_d    = IN_DATA;
          last_d  = IN_LAST;
          cnt_d   = 3'd0;
        end
        SHIFT: begin
          crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
          sh_d  = {sh_q[6:0], 1'b0};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = last_q ? DONE : IDLE;
        end
        DONE: begin
          crc_out_d   = crc_q;
          crc_valid_d = 1'b1;
          crc_d       = INIT;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      sh_q        <= 8'h00;
      cnt_q       <= 3'd0;
      last_q      <= 1'b0;
      crc_out_q   <= 8'h00;
      crc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      crc_out_q   <= crc_out_d;
      crc_valid_q <= crc_valid_d;
    end
  end
endmodule

// File: tb/tb_crc8_serial_unit.sv
// tb_crc8_serial_unit: directed and randomized checks of crc8_serial_unit against a polynomial-division CRC model
module tb_crc8_serial_unit;
  logic       CLK = 1'b0, RST = 1'b1, CLR = 1'b0, IN_VALID = 1'b0, IN_LAST = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_READY, CRC_VALID, BUSY;
  logic [7:0] CRC_OUT;
  int         vectors = 0, errs = 0, cyc = 0, strobes = 0;
  int         acc_q[$];
  logic [7:0] msg[$];
  crc8_serial_unit dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .CRC_OUT(CRC_OUT), .CRC_VALID(CRC_VALID), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (CRC_VALID === 1'b1) strobes <= strobes + 1;
  function automatic logic [7:0] ref_crc(input logic [7:0] m[$]);
    logic [15:0] r;
    logic [7:0]  c;
    c = 8'h00;
    foreach (m[i]) begin
      r = {c ^ m[i], 8'h00};
      for (int b = 15; b >= 8; b--) if (r[b]) r = r ^ (16'h0107 << (b - 8));
      c = r[7:0];
    end
    return c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l, input bit hold, output int acc);
    int n;
    n = 0;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = l;
    while (IN_READY !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) chk("ready_timeout", 32'(n), 32'd0);
    @(negedge CLK);
    acc = cyc;
    if (!hold) IN_VALID = 1'b0;
  endtask
  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (CRC_VALID !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) chk({tag, "_strobe_timeout"}, 32'(n), 32'd0);
  endtask
  task automatic frame(input logic [7:0] m[$], input string tag);
    int a;
    acc_q = {};
    foreach (m[i]) begin
      send(m[i], i == m.size() - 1, i != m.size() - 1, a);
      acc_q.push_back(a);
    end
    wait_strobe(tag);
    chk(tag, 32'(CRC_OUT), 32'(ref_crc(m)));
  endtask
  initial begin
    int a, k, s0, len;
    repeat (2) @(negedge CLK);
    chk("rst_crc_out", 32'(CRC_OUT), 32'h00);
    chk("rst_valid", 32'(CRC_VALID), 32'd0);
    chk("rst_ready", 32'(IN_READY), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    send(8'h01, 1'b1, 1'b0, a);
    k = 0;
    while (IN_READY !== 1'b1 && k < 20) begin
      chk("t1_no_early_strobe", 32'(CRC_VALID), 32'd0);
      @(negedge CLK);
      k++;
    end
    chk("t1_ready_low_cycles", 32'(k), 32'd9);
    chk("t1_strobe", 32'(CRC_VALID), 32'd1);
    chk("t1_crc", 32'(CRC_OUT), 32'h07);
    @(negedge CLK);
    chk("t1_strobe_one_cycle", 32'(CRC_VALID), 32'd0);
    chk("t1_crc_held", 32'(CRC_OUT), 32'h07);
    msg = {};
    for (int i = 0; i < 9; i++) msg.push_back(8'(8'h31 + i));
    s0 = strobes;
    frame(msg, "t2_model");
    chk("t2_crc", 32'(CRC_OUT), 32'hF4);
    for (int i = 1; i < 9; i++) chk("t2_throughput", 32'(acc_q[i] - acc_q[i-1]), 32'd9);
    @(negedge CLK);
    chk("t2_one_strobe", 32'(strobes - s0), 32'd1);
    msg = {8'hFF};
    frame(msg, "t3_ff_model");
    chk("t3_ff", 32'(CRC_OUT), 32'hF3);
    msg = {8'h00};
    frame(msg, "t3_00_model");
    chk("t3_00", 32'(CRC_OUT), 32'h00);
    @(negedge CLK);
    s0 = strobes;
    send(8'h31, 1'b1, 1'b0, a);
    repeat (3) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("t4_clr_idle", 32'(IN_READY), 32'd1);
    chk("t4_clr_busy", 32'(BUSY), 32'd0);
    chk("t4_clr_no_strobe", 32'(CRC_VALID), 32'd0);
    CLR = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = 8'h55;
    IN_LAST = 1'b1;
    @(negedge CLK);
    chk("t4_clr_blocks_accept", 32'(BUSY), 32'd0);
    CLR = 1'b0;
    IN_VALID = 1'b0;
    msg = {8'h01};
    frame(msg, "t4_model");
    chk("t4_crc", 32'(CRC_OUT), 32'h07);
    @(negedge CLK);
    chk("t4_single_strobe", 32'(strobes - s0), 32'd1);
    msg = {};
    for (int i = 0; i < 9; i++) msg.push_back(8'(8'h31 + i));
    frame(msg, "t5_pre_model");
    send(8'h31, 1'b1, 1'b0, a);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("t5_crc_out", 32'(CRC_OUT), 32'h00);
    chk("t5_ready", 32'(IN_READY), 32'd1);
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_valid", 32'(CRC_VALID), 32'd0);
    send(8'hA5, 1'b1, 1'b1, a);
    repeat (9) begin
      chk("t6_busy_hold", 32'(IN_READY), 32'd0);
      IN_DATA = 8'($urandom);
      IN_LAST = 1'($urandom);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    msg = {8'hA5};
    chk("t6_strobe", 32'(CRC_VALID), 32'd1);
    chk("t6_crc", 32'(CRC_OUT), 32'(ref_crc(msg)));
    @(negedge CLK);
    chk("t6_no_extra_accept", 32'(BUSY), 32'd0);
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 5);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      frame(msg, "rand_frame");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
